// File: rtl/op_dispatch_pkg.sv
// Shared constants for the order dispatcher: opcode encodings, one-hot state
// indices, order-pulse bit positions and the answer timeout.
package op_dispatch_pkg;

  typedef enum logic [2:0] {
    OpAdd    = 3'b000,
    OpSub    = 3'b001,
    OpMul    = 3'b010,
    OpDiv    = 3'b011,
    OpAnd    = 3'b100,
    OpAddAbs = 3'b101,
    OpSubAbs = 3'b110,
    OpCmp    = 3'b111
  } opcode_e;

  // One-hot state bit positions.
  localparam int unsigned StIdleIdx  = 0;
  localparam int unsigned StIssueIdx = 1;
  localparam int unsigned StWaitIdx  = 2;
  localparam int unsigned StDoneIdx  = 3;
  localparam int unsigned StOvfIdx   = 4;
  localparam int unsigned NumStates  = 5;

  typedef enum logic [NumStates-1:0] {
    StIdle  = 5'b00001,
    StIssue = 5'b00010,
    StWait  = 5'b00100,
    StDone  = 5'b01000,
    StOvf   = 5'b10000
  } state_e;

  // Order pulse bit positions.
  localparam int unsigned OrdAdd    = 0;
  localparam int unsigned OrdSub    = 1;
  localparam int unsigned OrdMul    = 2;
  localparam int unsigned OrdDiv    = 3;
  localparam int unsigned OrdAnd    = 4;
  localparam int unsigned NumOrders = 5;

  // Cycles allowed in WAIT before declaring overflow.
  localparam int unsigned TimeoutCycles = 100;
  localparam int unsigned CntW          = 7;
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);

  // Map an opcode onto the single controller order it issues.
  function automatic logic [NumOrders-1:0] order_onehot(opcode_e op);
    logic [NumOrders-1:0] ord;
    ord = '0;
    unique case (op)
      OpAdd, OpAddAbs:        ord[OrdAdd] = 1'b1;
      OpSub, OpSubAbs, OpCmp: ord[OrdSub] = 1'b1;
      OpMul:                  ord[OrdMul] = 1'b1;
      OpDiv:                  ord[OrdDiv] = 1'b1;
      OpAnd:                  ord[OrdAnd] = 1'b1;
      default:                ord = '0;
    endcase
    return ord;
  endfunction

  function automatic logic is_abs_op(opcode_e op);
    return (op == OpAddAbs) || (op == OpSubAbs);
  endfunction

endpackage

// File: rtl/op_dispatch.sv
// Order dispatcher: accepts one opcode from the PU, issues a single order pulse
// to the arithmetic controller, then waits for its answer or a timeout.
module op_dispatch
  import op_dispatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_from_pu,
  input  logic [2:0] opcode_from_pu,
  input  logic       clear_a_from_pu,
  input  logic       au_answer_from_ctrl,
  input  logic       reg_b_sign_from_ctrl,
  output logic       order_add_to_ctrl,
  output logic       order_sub_to_ctrl,
  output logic       order_mul_to_ctrl,
  output logic       order_div_to_ctrl,
  output logic       order_and_to_ctrl,
  output logic       ctrl_abs_to_ctrl,
  output logic       busy_to_pu,
  output logic       done_to_pu,
  output logic       overflow_to_pu,
  output logic       result_sign_to_pu
);

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  opcode_e               r_opcode;
  logic [NumOrders-1:0]  r_order;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_sign;

  opcode_e w_opcode_in;
  assign w_opcode_in = opcode_e'(opcode_from_pu);

  // Dispatcher FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_opcode <= OpAdd;
      r_order  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
    end else if (clear_a_from_pu) begin
      // Abort wins over start and answer; result sign is kept.
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_order  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_order <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_from_pu) begin
            // Order pulse is registered here so it is visible in ISSUE.
            r_opcode <= w_opcode_in;
            r_order  <= order_onehot(w_opcode_in);
            r_busy   <= 1'b1;
            r_state  <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          // The answer wins over the timeout in the same cycle.
          if (au_answer_from_ctrl) begin
            r_sign  <= reg_b_sign_from_ctrl;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (r_cnt == CntLast) begin
            r_ovf   <= 1'b1;
            r_state <= StOvf;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        StDone, StOvf: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign order_add_to_ctrl = r_order[OrdAdd];
  assign order_sub_to_ctrl = r_order[OrdSub];
  assign order_mul_to_ctrl = r_order[OrdMul];
  assign order_div_to_ctrl = r_order[OrdDiv];
  assign order_and_to_ctrl = r_order[OrdAnd];
  // Busy covers ISSUE..DONE/OVF exactly, so abs mode tracks the same window.
  assign ctrl_abs_to_ctrl  = r_busy & is_abs_op(r_opcode);
  assign busy_to_pu        = r_busy;
  assign done_to_pu        = r_done;
  assign overflow_to_pu    = r_ovf;
  assign result_sign_to_pu = r_sign;

endmodule
